// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared state enum, default widths and address decoder for the register-bank write path.
package reg_bank_pkg;
  typedef enum logic {IDLE, WRITE} state_e;
  localparam int DW = 8;
  localparam int NREG = 8;
  localparam int NREQ = 4;
  localparam int MAX_NREG = 16;
  function automatic logic [MAX_NREG-1:0] onehot_dec(input logic [3:0] addr);
    onehot_dec = '0;
    onehot_dec[addr] = 1'b1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; first valid index after last, wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] winner_o,
  output logic          any_o
);
  logic found;
  always_comb begin
    winner_o = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && valid_i[IW'((int'(last_i) + k) % N)]) begin
        winner_o = IW'((int'(last_i) + k) % N);
        found = 1'b1;
      end
    end
  end
  assign any_o = |valid_i;
endmodule

// File: rtl/reg_bank_write_arbiter.sv
// reg_bank_write_arbiter: round-robin write arbiter feeding a shared register bank.
// Optional REG_ARB_LOCK_EN adds req_lock so the current winner keeps priority.
module reg_bank_write_arbiter #(
  parameter int NREQ = reg_bank_pkg::NREQ,
  parameter int NREG = reg_bank_pkg::NREG,
  parameter int DW = reg_bank_pkg::DW,
  parameter int AW = $clog2(NREG),
  parameter int IW = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef REG_ARB_LOCK_EN
  input  logic             req_lock,
`endif
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREG-1:0]    reg_en,
  output logic [DW-1:0]      reg_d,
  output logic [IW-1:0]      grant_id,
  output logic               busy
);
  import reg_bank_pkg::*;
  state_e state_q, state_d;
  logic [IW-1:0] last_q, last_d, gid_q, gid_d, win;
  logic [NREQ-1:0] ready_q, ready_d;
  logic [NREG-1:0] en_q, en_d;
  logic [DW-1:0] d_q, d_d;
  logic any;
  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .valid_i(req_valid),
    .last_i(last_q),
    .winner_o(win),
    .any_o(any)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= IW'(NREQ - 1);
      gid_q <= '0;
      ready_q <= '0;
      en_q <= '0;
      d_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      gid_q <= gid_d;
      ready_q <= ready_d;
      en_q <= en_d;
      d_q <= d_d;
    end
  end
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    gid_d = gid_q;
    d_d = d_q;
    ready_d = '0;
    en_d = '0;
    if (state_q == IDLE && any) begin
      state_d = WRITE;
      last_d = win;
      gid_d = win;
      d_d = req_data[int'(win)*DW +: DW];
      // Addresses at or above NREG fall outside the truncated decode, so the write is dropped.
      en_d = NREG'(onehot_dec(4'(req_addr[int'(win)*AW +: AW])));
      ready_d = NREQ'(1) << win;
    end else if (state_q == WRITE) begin
      state_d = IDLE;
`ifdef REG_ARB_LOCK_EN
      if (req_lock) last_d = (gid_q == '0) ? IW'(NREQ - 1) : gid_q - 1'b1;
`endif
    end
  end
  assign req_ready = ready_q;
  assign reg_en = en_q;
  assign reg_d = d_q;
  assign grant_id = gid_q;
  assign busy = (state_q == WRITE);
endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// tb_reg_bank_write_arbiter: directed vectors for the register-bank write arbiter.
module tb_reg_bank_write_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [3:0] req_valid;
  logic [11:0] req_addr;
  logic [31:0] req_data;
  logic req_lock;
  logic [3:0] req_ready, ready_o;
  logic [7:0] reg_en, reg_d, d_o;
  logic [4:0] en_o;
  logic [1:0] grant_id, gid_o;
  logic busy, busy_o;
  int total = 0;
  int bad = 0;
  reg_bank_write_arbiter dut (
    .clk(clk), .rst(rst),
`ifdef REG_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .reg_en(reg_en), .reg_d(reg_d), .grant_id(grant_id), .busy(busy)
  );
  reg_bank_write_arbiter #(.NREG(5)) dut_o (
    .clk(clk), .rst(rst),
`ifdef REG_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(ready_o), .reg_en(en_o), .reg_d(d_o), .grant_id(gid_o), .busy(busy_o)
  );
  logic [7:0] bank [8];
  logic [7:0] exp_bank [8];
  logic [7:0] exp_known;
  always @(posedge clk)
    for (int r = 0; r < 8; r++) if (reg_en[r]) bank[r] <= reg_d;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr_chk(input string nm, input logic [1:0] gid, input logic [7:0] en, input logic [7:0] d);
    chk({nm, "_gid"}, 32'(grant_id), 32'(gid));
    chk({nm, "_en"}, 32'(reg_en), 32'(en));
    chk({nm, "_d"}, 32'(reg_d), 32'(d));
    chk({nm, "_rdy"}, 32'(req_ready), 32'(4'(1) << gid));
    chk({nm, "_busy"}, 32'(busy), 32'd1);
  endtask
  task automatic idle_chk(input string nm, input logic [1:0] gid, input logic [7:0] d);
    chk({nm, "_ien"}, 32'(reg_en), 32'd0);
    chk({nm, "_irdy"}, 32'(req_ready), 32'd0);
    chk({nm, "_ibusy"}, 32'(busy), 32'd0);
    chk({nm, "_id"}, 32'(reg_d), 32'(d));
    chk({nm, "_igid"}, 32'(grant_id), 32'(gid));
  endtask
  typedef struct {
    logic [3:0] v;
    logic [1:0] gid;
    logic [7:0] en;
    logic [7:0] d;
  } vec_t;
  vec_t tbl [10];
  localparam logic [11:0] ADDRS = {3'd6, 3'd4, 3'd2, 3'd1};
  localparam logic [31:0] DATAS = {8'h43, 8'h32, 8'h21, 8'h10};
  initial begin
    tbl[0] = '{4'b1111, 2'd0, 8'h02, 8'h10};
    tbl[1] = '{4'b1111, 2'd1, 8'h04, 8'h21};
    tbl[2] = '{4'b1111, 2'd2, 8'h10, 8'h32};
    tbl[3] = '{4'b1111, 2'd3, 8'h40, 8'h43};
    tbl[4] = '{4'b1111, 2'd0, 8'h02, 8'h10};
    tbl[5] = '{4'b0100, 2'd2, 8'h10, 8'h32};
    tbl[6] = '{4'b1101, 2'd3, 8'h40, 8'h43};
    tbl[7] = '{4'b1101, 2'd0, 8'h02, 8'h10};
    tbl[8] = '{4'b0010, 2'd1, 8'h04, 8'h21};
    tbl[9] = '{4'b1001, 2'd3, 8'h40, 8'h43};
    exp_known = '0;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    req_lock = 1'b0;
    #2;
    chk("rst_en", 32'(reg_en), 0);
    chk("rst_d", 32'(reg_d), 0);
    chk("rst_rdy", 32'(req_ready), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    #10 rst = 1'b0;
    req_valid = 4'b0001;
    req_addr = 12'd3;
    req_data = 32'hA5;
    tick;
    wr_chk("single", 2'd0, 8'h08, 8'hA5);
    exp_bank[3] = 8'hA5;
    exp_known[3] = 1'b1;
    req_valid = '0;
    tick;
    idle_chk("single", 2'd0, 8'hA5);
    rst = 1'b1;
    #4 rst = 1'b0;
    req_addr = ADDRS;
    req_data = DATAS;
    for (int i = 0; i < 10; i++) begin
      req_valid = tbl[i].v;
      tick;
      wr_chk($sformatf("vec%0d", i), tbl[i].gid, tbl[i].en, tbl[i].d);
      for (int r = 0; r < 8; r++) if (tbl[i].en[r]) begin
        exp_bank[r] = tbl[i].d;
        exp_known[r] = 1'b1;
      end
      tick;
      idle_chk($sformatf("vec%0d", i), tbl[i].gid, tbl[i].d);
    end
    for (int r = 0; r < 8; r++)
      if (exp_known[r]) chk($sformatf("bank%0d", r), 32'(bank[r]), 32'(exp_bank[r]));
    req_valid = 4'b0001;
    req_addr = 12'd6;
    req_data = 32'h5A;
    tick;
    chk("oor_en", 32'(en_o), 0);
    chk("oor_rdy", 32'(ready_o), 32'h1);
    chk("oor_busy", 32'(busy_o), 1);
    chk("oor_main_en", 32'(reg_en), 32'h40);
    req_valid = '0;
    tick;
    chk("oor_en2", 32'(en_o), 0);
    chk("oor_rdy2", 32'(ready_o), 0);
    req_valid = 4'b0001;
    req_addr = 12'd1;
    req_data = 32'hEE;
    tick;
    wr_chk("abort_pre", 2'd0, 8'h02, 8'hEE);
    #2 rst = 1'b1;
    #1;
    chk("abort_en", 32'(reg_en), 0);
    chk("abort_rdy", 32'(req_ready), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_d", 32'(reg_d), 0);
    chk("abort_gid", 32'(grant_id), 0);
    req_valid = '0;
    tick;
    rst = 1'b0;
    chk("abort_bank", 32'(bank[1]), 32'h10);
    req_valid = 4'b1111;
    req_addr = ADDRS;
    req_data = DATAS;
    tick;
    wr_chk("post_rst", 2'd0, 8'h02, 8'h10);
    req_valid = '0;
    tick;
    idle_chk("post_rst", 2'd0, 8'h10);
`ifdef REG_ARB_LOCK_EN
    rst = 1'b1;
    #2 rst = 1'b0;
    req_lock = 1'b1;
    req_valid = 4'b0010;
    tick;
    wr_chk("lock0", 2'd1, 8'h04, 8'h21);
    req_valid = 4'b1111;
    tick;
    tick;
    wr_chk("lock1", 2'd1, 8'h04, 8'h21);
    tick;
    tick;
    wr_chk("lock2", 2'd1, 8'h04, 8'h21);
    req_lock = 1'b0;
    tick;
    tick;
    wr_chk("unlock", 2'd2, 8'h10, 8'h32);
    req_valid = '0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
